button_press_decoder: RTL and testbench
=======================================

// Module: button_press_decoder
// PURPOSE
//  Consumes the clean level from the switch debouncer and turns each press into events:
//  - a one-cycle ShortPress on release
//  - a one-cycle LongPress once the hold time is exceeded
//  - optional auto-repeat pulses while the button stays held
//  Sits between the debouncer and the stopwatch control FSM (start/stop, lap, clear).
// PARAMETERS
//  LONG_CYCLES    100_000_000  cycles held in PRESSED before long-press (1 s @100 MHz); >=2
//  REPEAT_CYCLES   25_000_000  auto-repeat period in LONG state; >=1
//  CNT_W                   27  counter width; 2^CNT_W > max(LONG_CYCLES,REPEAT_CYCLES)-1
// PORTS
//  CLOCK        in   1  system clock, all logic on posedge
//  Reset        in   1  synchronous, active-high reset
//  DebouncedIn  in   1  debounced button level, 1 = pressed, synchronous to CLOCK
//  ShortPress   out  1  1-cycle pulse: released before long threshold
//  LongPress    out  1  1-cycle pulse: long threshold reached
//  RepeatPulse  out  1  1-cycle pulse every REPEAT_CYCLES in LONG (macro only)
//  Held         out  1  level: 1 while state is PRESSED or LONG
// BEHAVIOUR
//  - All outputs registered. Reset (sync, high) forces:
//    state=IDLE, count=0, ShortPress=LongPress=RepeatPulse=Held=0.
//  - Reset has priority over every other event.
//  - States (2-bit): IDLE=0, PRESSED=1, LONG=2; encoding 3 is illegal and recovers to IDLE next edge.
//  - IDLE: count=0.
//    DebouncedIn=1 -> PRESSED, count<=0, Held<=1.
//  - PRESSED:
//    DebouncedIn=0 -> IDLE, ShortPress<=1, Held<=0.
//    else if count==LONG_CYCLES-1 -> LONG, LongPress<=1, count<=0.
//    else count<=count+1.
//  - LONG:
//    DebouncedIn=0 -> IDLE, Held<=0, no ShortPress.
//    else see CONFIGURATION.
//  - Pulses are high for exactly one cycle and default to 0 on every other edge.
//  - Timing: first high sample at edge 0. If the level stays high through edges 0..N-1
//    and is low at edge N:
//    N<=LONG_CYCLES -> ShortPress high in the cycle after edge N;
//    N>LONG_CYCLES  -> LongPress high in the cycle after edge LONG_CYCLES and no ShortPress.
//  - Simultaneous: release at the edge where count==LONG_CYCLES-1 -> short press wins.
//  - Reset mid-press: press is discarded, no pulse is emitted. If DebouncedIn is still 1
//    after Reset falls, it is a new press counted from 0.
//  - Back-to-back presses separated by one low cycle produce two independent events.
//  - Counter never wraps: it is cleared on every state change and bounded by the compare.
// CONFIGURATION
//  Macro AUTO_REPEAT_EN:
//  - defined: in LONG with DebouncedIn=1, count increments. When count==REPEAT_CYCLES-1:
//    RepeatPulse<=1, count<=0. First repeat is REPEAT_CYCLES cycles after LongPress.
//    Release in the same edge suppresses the repeat.
//  - undefined: RepeatPulse tied to 0, count held at 0 in LONG, repeat logic absent.
//    Port list is identical in both builds.
// TESTING  (LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4)
//  1. Reset=1 for 3 edges with DebouncedIn=1 -> all outputs 0 throughout.
//     After Reset drops -> Held=1 next cycle.
//  2. High 5 edges, then low -> Held high 5 cycles; ShortPress single cycle after release edge;
//     LongPress=0.
//  3. High exactly 8 edges, then low (boundary) -> ShortPress once, LongPress never.
//  4. High 9 edges, then low -> LongPress once after edge 8; no ShortPress on release.
//  5. High 20 edges -> LongPress after edge 8.
//     With AUTO_REPEAT_EN: RepeatPulse after edges 12 and 16 only.
//     Without: RepeatPulse=0.
//  6. High, Reset pulse at edge 4, input kept high 6 more edges then low ->
//     no LongPress; one ShortPress.
//     Then pattern 1,0,1,0 (single cycles) -> two ShortPress pulses.

Source files
------------

// File: rtl/button_press_decoder.sv
// Turns a debounced button level into ShortPress / LongPress pulses and a Held level.
// Define AUTO_REPEAT_EN to add RepeatPulse generation while the button stays held in LONG.
module button_press_decoder #(
   parameter int unsigned LONG_CYCLES   = 100_000_000,
   parameter int unsigned REPEAT_CYCLES = 25_000_000,
   parameter int unsigned CNT_W         = 27
) (
   input  logic CLOCK,
   input  logic Reset,
   input  logic DebouncedIn,
   output logic ShortPress,
   output logic LongPress,
   output logic RepeatPulse,
   output logic Held
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             short_q, short_d;
   logic             long_q,  long_d;
   logic             held_q,  held_d;

`ifdef AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
   logic             rep_q, rep_d;
`endif

   always_comb begin
      // NOTE: every always_comb output is given a default first so no path can infer a latch.
      state_d = state_q;
      count_d = count_q;
      short_d = 1'b0;
      long_d  = 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            count_d = '0;
            if (DebouncedIn) state_d = PRESSED;
         end
         PRESSED: begin
            if (!DebouncedIn) begin
               // A release on the threshold edge still counts as a short press.
               state_d = IDLE;
               short_d = 1'b1;
               count_d = '0;
            end else if (count_q == LONG_LAST) begin
               state_d = LONG;
               long_d  = 1'b1;
               count_d = '0;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         LONG: begin
            if (!DebouncedIn) begin
               state_d = IDLE;
               count_d = '0;
            end else begin
`ifdef AUTO_REPEAT_EN
               if (count_q == REPEAT_LAST) begin
                  rep_d   = 1'b1;
                  count_d = '0;
               end else begin
                  count_d = count_q + 1'b1;
               end
`else
               count_d = '0;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
      held_d = (state_d == PRESSED) || (state_d == LONG);
   end

   always_ff @(posedge CLOCK) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (Reset) begin
         state_q <= IDLE;
         count_q <= '0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         short_q <= short_d;
         long_q  <= long_d;
         held_q  <= held_d;
      end
   end

`ifdef AUTO_REPEAT_EN
   always_ff @(posedge CLOCK) begin
      if (Reset) rep_q <= 1'b0;
      else       rep_q <= rep_d;
   end
   assign RepeatPulse = rep_q;
`else
   assign RepeatPulse = 1'b0;
`endif

   assign ShortPress = short_q;
   assign LongPress  = long_q;
   assign Held       = held_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Self-checking bench for button_press_decoder: directed scenarios plus random presses,
// compared against a run-length model of the button behaviour.
module tb_button_press_decoder;

   localparam int unsigned L = 8;
   localparam int unsigned R = 4;
   localparam int unsigned W = 4;

   logic clk = 1'b0;
   logic rst;
   logic din;
   logic short_o, long_o, rep_o, held_o;

   int n_vec = 0;
   int n_err = 0;
   int run   = 0;  // consecutive high samples of the current press since reset/release

   always #5 clk = ~clk;

   button_press_decoder #(
      .LONG_CYCLES  (L),
      .REPEAT_CYCLES(R),
      .CNT_W        (W)
   ) dut (
      .CLOCK      (clk),
      .Reset      (rst),
      .DebouncedIn(din),
      .ShortPress (short_o),
      .LongPress  (long_o),
      .RepeatPulse(rep_o),
      .Held       (held_o)
   );

   task automatic check(input string tag, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %b expected %b (run=%0d)", tag, $time, got, exp, run);
      end
   endtask

   // Apply one cycle of inputs, advance one edge, then compare against the model.
   task automatic step(input logic r, input logic d);
      logic e_short, e_long, e_rep, e_held;
      rst = r;
      din = d;
      @(posedge clk);
      #1;
      e_short = 1'b0;
      e_long  = 1'b0;
      e_rep   = 1'b0;
      e_held  = 1'b0;
      if (r) begin
         run = 0;
      end else if (d) begin
         run++;
         e_held = 1'b1;
         e_long = (run == L + 1);
`ifdef AUTO_REPEAT_EN
         e_rep  = (run > L + 1) && (((run - (L + 1)) % R) == 0);
`endif
      end else begin
         e_short = (run > 0) && (run <= L);
         run = 0;
      end
      check("ShortPress",  short_o, e_short);
      check("LongPress",   long_o,  e_long);
      check("RepeatPulse", rep_o,   e_rep);
      check("Held",        held_o,  e_held);
   endtask

   task automatic press(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      din = 1'b0;
      step(1'b1, 1'b0);
      // Reset held with the button pressed, then release reset.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      press(5);
      step(1'b0, 1'b0);
      press(L);
      step(1'b0, 1'b0);
      press(L + 1);
      step(1'b0, 1'b0);
      press(20);
      step(1'b0, 1'b0);
      // Reset in the middle of a press; the level stays high afterwards.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      press(6);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      for (int p = 0; p < 60; p++) begin
         int len;
         int gap;
         len = int'($urandom_range(1, 3 * L));
         gap = int'($urandom_range(1, 3));
         for (int i = 0; i < len; i++)
            step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0, 1'b1);
         for (int i = 0; i < gap; i++)
            step(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
